// File: rtl/morphologic_sequencer.sv
// Binary morphology sequencer: erode/dilate primitives on a registered working image,
// sequenced by an IDLE/PHASE_A/PHASE_B machine into open, close, gradient, top-hat and black-hat.
module morphologic_sequencer #(
  parameter int ImageWidth  = 8,
  parameter int ImageHeight = 4,
  parameter int ElSize      = 3,
  parameter int IterWidth   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ImageWidth*ImageHeight-1:0] img,
  input  logic [ElSize*ElSize-1:0]          el,
  input  logic [2:0]                        op,
  input  logic [IterWidth-1:0]              iterations,
  output logic                              busy,
  output logic                              done,
  output logic [ImageWidth*ImageHeight-1:0] result
);

  localparam int W  = ImageWidth;
  localparam int H  = ImageHeight;
  localparam int K  = ElSize;
  localparam int C  = ElSize / 2;
  localparam int NP = ImageWidth * ImageHeight;
  localparam int NE = ElSize * ElSize;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int EW = (NE > 1) ? $clog2(NE) : 1;

  localparam logic [2:0] OP_ID   = 3'b000;
  localparam logic [2:0] OP_ERO  = 3'b001;
  localparam logic [2:0] OP_DIL  = 3'b010;
  localparam logic [2:0] OP_GRAD = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PHASE_A = 2'd1,
    PHASE_B = 2'd2
  } state_t;

  // One erode (dil=0) or dilate (dil=1) pass; pixels outside the image read as 0.
  function automatic logic [NP-1:0] prim_f(input logic [NP-1:0] src,
                                           input logic [NE-1:0] se,
                                           input logic          dil);
    logic [NP-1:0] res;
    logic          acc;
    logic          pix;
    int            rr;
    int            cc;
    res = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        acc = ~dil;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            rr = dil ? r - (i - C) : r + (i - C);
            cc = dil ? c - (j - C) : c + (j - C);
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) pix = src[PW'((H - 1 - rr) * W + (W - 1 - cc))];
            else pix = 1'b0;
            if (!se[EW'((K - 1 - i) * K + (K - 1 - j))]) acc = acc;
            else if (dil) acc = acc | pix;
            else acc = acc & pix;
          end
        end
        res[PW'((H - 1 - r) * W + (W - 1 - c))] = acc;
      end
    end
    return res;
  endfunction

  state_t               state_r, state_s;
  logic [NP-1:0]        src_r, src_s;
  logic [NE-1:0]        el_r, el_s;
  logic [2:0]           op_r, op_s;
  logic [IterWidth-1:0] n_r, n_s;
  logic [IterWidth-1:0] cnt_r, cnt_s;
  logic [NP-1:0]        work_r, work_s;
  logic [NP-1:0]        aux_r, aux_s;
  logic [NP-1:0]        result_s;
  logic                 busy_s;
  logic                 done_s;
  logic                 dil_a_s;
  logic                 dil_b_s;
  logic [NP-1:0]        pass_a_s;
  logic [NP-1:0]        pass_b_s;
  logic [NP-1:0]        fin_s;
  logic                 last_s;

  // Primitive selection per phase; gradient dilates first so erode can restart from the source.
  always_comb begin
    dil_a_s = 1'b1;
    dil_b_s = 1'b0;
    case (op_r)
      3'b001, 3'b011, 3'b110: dil_a_s = 1'b0;
      default:                dil_a_s = 1'b1;
    endcase
    case (op_r)
      3'b011, 3'b110: dil_b_s = 1'b1;
      default:        dil_b_s = 1'b0;
    endcase
  end

  assign pass_a_s = prim_f(work_r, el_r, dil_a_s);
  assign pass_b_s = prim_f(work_r, el_r, dil_b_s);
  assign last_s   = (cnt_r == n_r - IterWidth'(1));

  // Final image combination at the end of PHASE_B.
  always_comb begin
    fin_s = pass_b_s;
    case (op_r)
      3'b101:  fin_s = aux_r & ~pass_b_s;
      3'b110:  fin_s = src_r & ~pass_b_s;
      3'b111:  fin_s = pass_b_s & ~src_r;
      default: fin_s = pass_b_s;
    endcase
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_s  = state_r;
    src_s    = src_r;
    el_s     = el_r;
    op_s     = op_r;
    n_s      = n_r;
    cnt_s    = cnt_r;
    work_s   = work_r;
    aux_s    = aux_r;
    result_s = result;
    busy_s   = busy;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          src_s   = img;
          el_s    = el;
          op_s    = op;
          n_s     = (iterations == '0) ? IterWidth'(1) : iterations;
          work_s  = img;
          aux_s   = '0;
          cnt_s   = '0;
          busy_s  = 1'b1;
          state_s = PHASE_A;
        end else begin
          state_s = IDLE;
        end
      end
      PHASE_A: begin
        if (op_r == OP_ID) begin
          result_s = src_r;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          state_s  = IDLE;
        end else if (!last_s) begin
          work_s = pass_a_s;
          cnt_s  = cnt_r + IterWidth'(1);
        end else if (op_r == OP_ERO || op_r == OP_DIL) begin
          work_s   = pass_a_s;
          result_s = pass_a_s;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          state_s  = IDLE;
        end else begin
          cnt_s   = '0;
          state_s = PHASE_B;
          if (op_r == OP_GRAD) begin
            aux_s  = pass_a_s;
            work_s = src_r;
          end else begin
            work_s = pass_a_s;
          end
        end
      end
      PHASE_B: begin
        if (!last_s) begin
          work_s = pass_b_s;
          cnt_s  = cnt_r + IterWidth'(1);
        end else begin
          work_s   = pass_b_s;
          result_s = fin_s;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, working registers and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      src_r   <= '0;
      el_r    <= '0;
      op_r    <= 3'b000;
      n_r     <= '0;
      cnt_r   <= '0;
      work_r  <= '0;
      aux_r   <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      el_r    <= el_s;
      op_r    <= op_s;
      n_r     <= n_s;
      cnt_r   <= cnt_s;
      work_r  <= work_s;
      aux_r   <= aux_s;
      result  <= result_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

endmodule

// File: tb/tb_morphologic_sequencer.sv
// Directed-vector bench for morphologic_sequencer on an 8x4 image with a 3x3 element.
module tb_morphologic_sequencer;

  localparam int NP = 32;
  localparam int NE = 9;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NP-1:0] img;
  logic [NE-1:0] el;
  logic [2:0]    op;
  logic [3:0]    iterations;
  logic          busy;
  logic          done;
  logic [NP-1:0] result;

  int total_cnt;
  int pass_cnt;

  morphologic_sequencer #(
    .ImageWidth (8),
    .ImageHeight(4),
    .ElSize     (3),
    .IterWidth  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img       (img),
    .el        (el),
    .op        (op),
    .iterations(iterations),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    else pass_cnt++;
  endtask

  // Launch one operation and check busy, completion latency, result and the one-cycle done pulse.
  task automatic run_op(input string tag, input logic [NP-1:0] i_img, input logic [NE-1:0] i_el,
                        input logic [2:0] i_op, input logic [3:0] i_n, input int exp_lat,
                        input logic [NP-1:0] exp_res);
    int k;
    @(negedge clk);
    img = i_img; el = i_el; op = i_op; iterations = i_n; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy"}, busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  localparam logic [NP-1:0] IMG_A   = 32'h00_08_10_00;
  localparam logic [NP-1:0] IMG_PIX = 32'h00_08_00_00;
  localparam logic [NP-1:0] IMG_BLK = 32'hE0_E0_E0_02;
  localparam logic [NP-1:0] IMG_SQ  = 32'hE0_E0_E0_00;
  localparam logic [NP-1:0] IMG_RNG = 32'hE0_A0_E0_00;
  localparam logic [NE-1:0] EL_CTR  = 9'b000_010_000;
  localparam logic [NE-1:0] EL_ONE  = 9'b111_111_111;
  localparam logic [NE-1:0] EL_CRS  = 9'b010_111_010;

  initial begin
    int extra;
    total_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1; start = 1'b0; img = '0; el = '0; op = 3'b000; iterations = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_res", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("ident", IMG_A, EL_CTR, 3'b000, 4'd1, 1, IMG_A);
    run_op("ero_ctr", IMG_A, EL_CTR, 3'b001, 4'd1, 1, IMG_A);
    run_op("ero_all", IMG_A, EL_ONE, 3'b001, 4'd1, 1, 32'h0);
    run_op("dil_n1", IMG_PIX, EL_CRS, 3'b010, 4'd1, 1, 32'h08_1C_08_00);
    run_op("dil_n2", IMG_PIX, EL_CRS, 3'b010, 4'd2, 2, 32'h1C_3E_1C_08);
    run_op("open", IMG_BLK, EL_ONE, 3'b011, 4'd1, 2, 32'hE0_E0_E0_00);
    run_op("tophat", IMG_BLK, EL_ONE, 3'b110, 4'd1, 2, 32'h00_00_00_02);
    run_op("close", IMG_RNG, EL_ONE, 3'b100, 4'd1, 2, 32'h00_60_60_00);
    run_op("blkhat", IMG_RNG, EL_ONE, 3'b111, 4'd1, 2, 32'h00_40_00_00);
    run_op("n_max", IMG_A, EL_CTR, 3'b010, 4'd15, 15, IMG_A);

    // Gradient with start re-pulsed at T1 and inputs scrambled while busy.
    @(negedge clk);
    img = IMG_SQ; el = EL_ONE; op = 3'b101; iterations = 4'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    img = 32'hFFFF_FFFF; el = '0; op = 3'b001;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("grad_done", done, 1'b1);
    chk("grad_res", result, 32'hF0_B0_F0_F0);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
      else extra = extra;
    end
    chk("grad_single", extra, 0);
    chk("grad_hold", result, 32'hF0_B0_F0_F0);

    // Start held high across the done edge: ignored there, accepted one cycle later.
    @(negedge clk);
    img = IMG_PIX; el = EL_CRS; op = 3'b010; iterations = 4'd1; start = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("sd_done", done, 1'b1);
    chk("sd_busy0", busy, 1'b0);
    @(posedge clk); #1;
    chk("sd_busy1", busy, 1'b1);
    chk("sd_nodone", done, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("sd_done2", done, 1'b1);
    chk("sd_res", result, 32'h08_1C_08_00);

    // Reset at T1 of a close with n=3 aborts without a done pulse.
    @(negedge clk);
    img = IMG_A; el = EL_CTR; op = 3'b100; iterations = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_res", result, 32'h0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
      else extra = extra;
    end
    chk("abort_quiet", extra, 0);
    run_op("close3", IMG_A, EL_CTR, 3'b100, 4'd3, 6, IMG_A);
    run_op("n_zero", IMG_PIX, EL_CRS, 3'b010, 4'd0, 1, 32'h08_1C_08_00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
